rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order WB stage and the multi-cycle mult/div unit.
- WB always wins the port; mult/div results are buffered in a small FIFO and drained on idle write-port cycles.
- A 32-entry busy scoreboard tracks registers with outstanding mult/div results, so decode stalls on RAW/WAW hazards.
- Sits between WB, the mult/div unit, the decode hazard logic and the register file (which samples the write port on negedge clk).

---
 rtl/rf_arb_pkg.sv | 22 ++
 rtl/md_result_fifo.sv | 68 ++++++
 rtl/rf_write_arbiter.sv | 106 ++++++++++
 tb/tb_rf_write_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared widths, constants and the buffered mult/div entry type
//               for the register-file write-port arbiter.
// Revision    : 1.0
// ============================================================================
package rf_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } md_entry_t;

endpackage
`default_nettype wire

// File: rtl/md_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : md_result_fifo
// Description : Circular buffer holding mult/div results awaiting a free
//               register-file write slot.
// Revision    : 1.0
// ============================================================================
module md_result_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  md_entry_t                    push_entry,
    input  logic                         pop,
    output md_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    md_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the register-file write port between WB (always wins)
//               and buffered mult/div results; tracks busy destinations.
//               Data/index widths come from rf_arb_pkg.
// Revision    : 1.0
// ============================================================================
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_issue,
    input  logic [ADDR_W-1:0] md_issue_reg,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_reg,
    input  logic [DATA_W-1:0] md_data,
    input  logic [ADDR_W-1:0] dec_rs,
    input  logic [ADDR_W-1:0] dec_rt,
    input  logic [ADDR_W-1:0] dec_rd,
    output logic              dec_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wreg,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    md_entry_t             w_head;
    md_entry_t             w_push_entry;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wb_win;
    logic                  w_push;
    logic                  w_pop;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;

    assign w_wb_win     = wb_we && (wb_reg != REG_ZERO);
    assign md_ready     = !rst && (w_count != CNT_W'(DEPTH));
    assign w_push       = md_valid && md_ready && !w_full;
    assign w_pop        = !rst && !w_wb_win && !w_empty;
    assign w_push_entry = '{dst: md_reg, data: md_data};

    md_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_count),
        .full       (w_full),
        .empty      (w_empty)
    );

    // A WB write to r0 leaves the port free, so the FIFO head may drain.
    always_comb begin
        rf_we    = 1'b0;
        rf_wreg  = REG_ZERO;
        rf_wdata = '0;
        if (w_wb_win) begin
            rf_we    = !rst;
            rf_wreg  = wb_reg;
            rf_wdata = wb_data;
        end else if (!w_empty) begin
            rf_we    = !rst && (w_head.dst != REG_ZERO);
            rf_wreg  = w_head.dst;
            rf_wdata = w_head.data;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head.dst] = 1'b0;
        end
        if (md_issue && (md_issue_reg != REG_ZERO)) begin
            w_busy_nxt[md_issue_reg] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign dec_stall = !rst && (r_busy[dec_rs] | r_busy[dec_rt] | r_busy[dec_rd]);

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed and randomized checks of rf_write_arbiter against a
//               queue-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_issue;
    logic [4:0]  md_issue_reg;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic        dec_stall;
    logic        rf_we;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata;

    rf_write_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_we        (wb_we),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .md_issue     (md_issue),
        .md_issue_reg (md_issue_reg),
        .md_valid     (md_valid),
        .md_ready     (md_ready),
        .md_reg       (md_reg),
        .md_data      (md_data),
        .dec_rs       (dec_rs),
        .dec_rt       (dec_rt),
        .dec_rd       (dec_rd),
        .dec_stall    (dec_stall),
        .rf_we        (rf_we),
        .rf_wreg      (rf_wreg),
        .rf_wdata     (rf_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending results in arrival order plus a busy flag per register.
    logic [4:0]  mq_reg[$];
    logic [31:0] mq_data[$];
    bit          mbusy[32];
    bit          last_accept;
    bit          rand_phase;
    logic [4:0]  inflight[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        int          n;
        logic        e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        if (rst) begin
            chk("md_ready_in_rst", {31'd0, md_ready}, 32'd0);
            chk("rf_we_in_rst", {31'd0, rf_we}, 32'd0);
            chk("dec_stall_in_rst", {31'd0, dec_stall}, 32'd0);
        end else begin
            n = mq_reg.size();
            if (wb_we && wb_reg != 5'd0) begin
                e_we = 1'b1; e_reg = wb_reg; e_data = wb_data;
            end else if (n > 0) begin
                e_we = (mq_reg[0] != 5'd0); e_reg = mq_reg[0]; e_data = mq_data[0];
            end else begin
                e_we = 1'b0; e_reg = 5'd0; e_data = 32'd0;
            end
            chk("md_ready", {31'd0, md_ready}, {31'd0, n < DEPTH});
            chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
            chk("rf_wreg", {27'd0, rf_wreg}, {27'd0, e_reg});
            chk("rf_wdata", rf_wdata, e_data);
            chk("dec_stall", {31'd0, dec_stall},
                {31'd0, mbusy[dec_rs] | mbusy[dec_rt] | mbusy[dec_rd]});
        end
    endtask

    task automatic model_update();
        bit pop;
        bit acc;
        if (rst) begin
            mq_reg.delete();
            mq_data.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            last_accept = 1'b0;
        end else begin
            pop = !(wb_we && wb_reg != 5'd0) && (mq_reg.size() > 0);
            acc = md_valid && (mq_reg.size() < DEPTH);
            if (pop) begin
                mbusy[mq_reg[0]] = 1'b0;
                void'(mq_reg.pop_front());
                void'(mq_data.pop_front());
            end
            if (acc) begin
                mq_reg.push_back(md_reg);
                mq_data.push_back(md_data);
            end
            if (md_issue && md_issue_reg != 5'd0) mbusy[md_issue_reg] = 1'b1;
            if (md_issue && rand_phase) inflight.push_back(md_issue_reg);
            mbusy[0] = 1'b0;
            last_accept = acc;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        wb_we = 0; wb_reg = 0; wb_data = 0;
        md_issue = 0; md_issue_reg = 0;
        md_valid = 0; md_reg = 0; md_data = 0;
        dec_rs = 0; dec_rt = 0; dec_rd = 0;
    endtask

    initial begin
        rst = 1;
        rand_phase = 0;
        last_accept = 0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        quiet();

        // Reset and idle
        settle(); advance();
        settle();
        chk("t1_ready_in_rst", {31'd0, md_ready}, 32'd0);
        chk("t1_we_in_rst", {31'd0, rf_we}, 32'd0);
        advance();
        rst = 0;
        settle();
        chk("t1_idle_ready", {31'd0, md_ready}, 32'd1);
        chk("t1_idle_we", {31'd0, rf_we}, 32'd0);
        chk("t1_idle_stall", {31'd0, dec_stall}, 32'd0);
        advance();

        // Reset while two entries wait behind WB
        md_issue = 1; md_issue_reg = 4; settle(); advance();
        md_issue_reg = 5; settle(); advance();
        md_issue = 0;
        wb_we = 1; wb_reg = 3; wb_data = 32'h0000_0333;
        md_valid = 1; md_reg = 4; md_data = 32'hAAAA_0004; settle(); advance();
        md_reg = 5; md_data = 32'hAAAA_0005; settle(); advance();
        md_valid = 0; dec_rs = 4;
        settle();
        chk("t1_full_ready", {31'd0, md_ready}, 32'd0);
        chk("t1_full_wreg", {27'd0, rf_wreg}, 32'd3);
        chk("t1_busy_stall", {31'd0, dec_stall}, 32'd1);
        advance();
        rst = 1; settle(); advance();
        rst = 0; wb_we = 0; dec_rs = 4; dec_rt = 5;
        settle();
        chk("t1_post_rst_ready", {31'd0, md_ready}, 32'd1);
        chk("t1_post_rst_we", {31'd0, rf_we}, 32'd0);
        chk("t1_post_rst_stall", {31'd0, dec_stall}, 32'd0);
        advance();
        quiet();

        // Single result, no WB traffic
        md_issue = 1; md_issue_reg = 8; settle(); advance();
        md_issue = 0; md_valid = 1; md_reg = 8; md_data = 32'h1234_5678; dec_rs = 8;
        settle();
        chk("t2_accept_ready", {31'd0, md_ready}, 32'd1);
        chk("t2_no_bypass", {31'd0, rf_we}, 32'd0);
        advance();
        md_valid = 0;
        settle();
        chk("t2_we", {31'd0, rf_we}, 32'd1);
        chk("t2_wreg", {27'd0, rf_wreg}, 32'd8);
        chk("t2_wdata", rf_wdata, 32'h1234_5678);
        chk("t2_stall_hold", {31'd0, dec_stall}, 32'd1);
        advance();
        settle();
        chk("t2_stall_drop", {31'd0, dec_stall}, 32'd0);
        advance();
        quiet();

        // WB holds the port while two results queue up
        md_issue = 1; md_issue_reg = 9; settle(); advance();
        md_issue_reg = 10; settle(); advance();
        md_issue = 0;
        wb_we = 1; wb_reg = 3; wb_data = 32'hCAFE_0003;
        md_valid = 1; md_reg = 9; md_data = 32'h9999_0009;
        settle(); chk("t3_wb1", {27'd0, rf_wreg}, 32'd3); advance();
        md_reg = 10; md_data = 32'h1010_0010;
        settle(); chk("t3_wb2", {27'd0, rf_wreg}, 32'd3); advance();
        md_valid = 0;
        settle();
        chk("t3_wb3", {27'd0, rf_wreg}, 32'd3);
        chk("t3_ready_full", {31'd0, md_ready}, 32'd0);
        advance();
        settle(); chk("t3_wb4", {27'd0, rf_wreg}, 32'd3); advance();
        wb_we = 0;
        settle();
        chk("t3_first_reg", {27'd0, rf_wreg}, 32'd9);
        chk("t3_first_data", rf_wdata, 32'h9999_0009);
        advance();
        settle();
        chk("t3_second_reg", {27'd0, rf_wreg}, 32'd10);
        chk("t3_second_data", rf_wdata, 32'h1010_0010);
        advance();
        settle(); chk("t3_drained", {31'd0, rf_we}, 32'd0); advance();
        quiet();

        // Full FIFO drains under a WB write to r0
        md_issue = 1; md_issue_reg = 13; settle(); advance();
        md_issue_reg = 14; settle(); advance();
        md_issue = 0; wb_we = 1; wb_reg = 3; wb_data = 32'h3;
        md_valid = 1; md_reg = 13; md_data = 32'h1313_1313; settle(); advance();
        md_reg = 14; md_data = 32'h1414_1414; settle(); advance();
        md_valid = 0; wb_reg = 0; wb_data = 32'hDEAD_BEEF;
        settle();
        chk("t4_full", {31'd0, md_ready}, 32'd0);
        chk("t4_r0_head_reg", {27'd0, rf_wreg}, 32'd13);
        chk("t4_r0_we", {31'd0, rf_we}, 32'd1);
        advance();
        wb_we = 0;
        settle();
        chk("t4_ready_after_pop", {31'd0, md_ready}, 32'd1);
        chk("t4_next_head", {27'd0, rf_wreg}, 32'd14);
        advance();
        quiet();

        // Results destined for r0
        md_issue = 1; md_issue_reg = 0;
        settle(); chk("t5_stall_r0_a", {31'd0, dec_stall}, 32'd0); advance();
        md_issue = 0; md_valid = 1; md_reg = 0; md_data = 32'h0F0F_0F0F;
        settle(); chk("t5_stall_r0_b", {31'd0, dec_stall}, 32'd0); advance();
        md_valid = 0;
        settle();
        chk("t5_r0_no_we", {31'd0, rf_we}, 32'd0);
        chk("t5_stall_r0_c", {31'd0, dec_stall}, 32'd0);
        advance();
        quiet();

        // Reissue of a register in the cycle its older result drains
        md_issue = 1; md_issue_reg = 12; settle(); advance();
        md_issue = 0; md_valid = 1; md_reg = 12; md_data = 32'h1212_0001; settle(); advance();
        md_valid = 0; md_issue = 1; md_issue_reg = 12;
        settle(); chk("t6_pop_reg", {27'd0, rf_wreg}, 32'd12); advance();
        md_issue = 0; dec_rs = 12;
        settle(); chk("t6_set_wins", {31'd0, dec_stall}, 32'd1); advance();
        md_valid = 1; md_reg = 12; md_data = 32'h1212_0002; settle(); advance();
        md_valid = 0; settle(); advance();
        settle(); chk("t6_cleared", {31'd0, dec_stall}, 32'd0); advance();
        quiet();

        // Randomized traffic
        rand_phase = 1;
        inflight.delete();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(199) == 0) begin
                rst = 1;
                md_valid = 0;
                md_issue = 0;
                inflight.delete();
            end else begin
                rst = 0;
                wb_we   = 1'($urandom_range(1));
                wb_reg  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                wb_data = $urandom;
                dec_rs  = 5'($urandom_range(31));
                dec_rt  = 5'($urandom_range(31));
                dec_rd  = 5'($urandom_range(31));
                md_issue_reg = dec_rd;
                md_issue = !(mbusy[dec_rs] | mbusy[dec_rt] | mbusy[dec_rd])
                           && ($urandom_range(2) == 0);
                if (!(md_valid && !last_accept)) begin
                    if (inflight.size() > 0 && $urandom_range(1) == 1) begin
                        md_valid = 1;
                        md_reg   = inflight.pop_front();
                        md_data  = $urandom;
                    end else begin
                        md_valid = 0;
                    end
                end
            end
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
